// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the pipelined OTTER MCU.
// Owns the PC and drives instruction-memory port 1, which returns data one cycle
// after the address. It registers each fetched instruction and its PC into the
// ID stage and exposes the opcode/funct3/funct7 fields for the decoder.
//
// Control semantics (one place, read this first):
//   - REDIRECT_VALID is a single-cycle command from EX. It is accepted on the
//     edge where it is high, always, even when STALL is also high. That edge
//     drops every instruction in flight and loads the word-aligned target.
//   - STALL is a level request from the hazard unit. While it is high, with no
//     redirect, the PC, the fetch tracking and the whole ID stage freeze.
//   - RST is synchronous and overrides both of the above.
//   - Memory read timing: the address on IMEM_ADDR while IMEM_RDEN=1 is sampled
//     on an edge, and its word shows up on IMEM_DOUT during the following cycle.
//     While stalled the read is disabled, so the word that was already in flight
//     when the stall began is caught once in a skid buffer and replayed from
//     there when the stage advances again.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        REDIRECT_VALID,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_RDEN,
  input  logic [31:0] IMEM_DOUT,
  output logic        ID_VALID,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC_PLUS4,
  output logic [31:0] ID_INSTR,
  output logic [6:0]  ID_OPCODE,
  output logic [2:0]  ID_FUNCT3,
  output logic        ID_FUNCT7
);

  // Address being issued to memory this cycle.
  logic [31:0] r_pc;
  // Address issued last cycle; IMEM_DOUT carries its word this cycle.
  logic [31:0] r_f_pc;
  logic        r_f_valid;
  // Skid buffer holding the word that arrived during the first stall cycle.
  logic [31:0] r_hold_instr;
  logic        r_hold_valid;
  // IF/ID pipeline register.
  logic        r_id_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_instr;

  logic [31:0] w_pc_next_seq;
  logic [31:0] w_redirect_target;
  logic [31:0] w_fetched_instr;
  logic        w_advance;
  logic        w_capture_skid;

  // Sequential fetch wraps modulo 2^32 with no overflow indication.
  assign w_pc_next_seq     = r_pc + 32'd4;
  // Misaligned targets are silently word-aligned.
  assign w_redirect_target = {REDIRECT_PC[31:2], 2'b00};
  // Word entering ID on an advance: replay the skid buffer if it holds
  // something, otherwise take the live memory data. A bubble when nothing valid
  // was in flight.
  assign w_fetched_instr   = !r_f_valid   ? NOP_INSTR    :
                             r_hold_valid ? r_hold_instr : IMEM_DOUT;
  assign w_advance         = !REDIRECT_VALID && !STALL;
  // Capture only on the first stall cycle; later cycles see stale memory data.
  assign w_capture_skid    = !REDIRECT_VALID && STALL && r_f_valid && !r_hold_valid;

  // Memory port is driven straight from the PC register.
  assign IMEM_ADDR = r_pc;
  assign IMEM_RDEN = !STALL || REDIRECT_VALID;

  // Decoder-facing fields come from the ID registers only.
  assign ID_VALID    = r_id_valid;
  assign ID_PC       = r_id_pc;
  assign ID_INSTR    = r_id_instr;
  assign ID_PC_PLUS4 = r_id_pc + 32'd4;
  assign ID_OPCODE   = r_id_instr[6:0];
  assign ID_FUNCT3   = r_id_instr[14:12];
  assign ID_FUNCT7   = r_id_instr[30];

  // PC register: reset, redirect target, hold on stall, else next sequential word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc <= RESET_PC;
    end else if (REDIRECT_VALID) begin
      r_pc <= w_redirect_target;
    end else if (w_advance) begin
      r_pc <= w_pc_next_seq;
    end
  end

  // Fetch tracking: remembers which address the current IMEM_DOUT belongs to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_f_pc    <= 32'd0;
      r_f_valid <= 1'b0;
    end else if (REDIRECT_VALID) begin
      // The target was not read yet; the old in-flight word is squashed.
      r_f_valid <= 1'b0;
    end else if (w_advance) begin
      r_f_pc    <= r_pc;
      r_f_valid <= 1'b1;
    end
  end

  // Skid buffer: catch the in-flight word once per stall, drop it on any flow change.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hold_instr <= NOP_INSTR;
      r_hold_valid <= 1'b0;
    end else if (REDIRECT_VALID || w_advance) begin
      r_hold_valid <= 1'b0;
    end else if (w_capture_skid) begin
      r_hold_instr <= IMEM_DOUT;
      r_hold_valid <= 1'b1;
    end
  end

  // IF/ID register: bubble on redirect, freeze on stall, else load the fetched word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_id_valid <= 1'b0;
      r_id_pc    <= 32'd0;
      r_id_instr <= NOP_INSTR;
    end else if (REDIRECT_VALID) begin
      // ID_PC is left alone; only validity and the instruction are squashed.
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
    end else if (w_advance) begin
      r_id_valid <= r_f_valid;
      r_id_pc    <= r_f_pc;
      r_id_instr <= w_fetched_instr;
    end
  end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the pipelined OTTER MCU. Sits directly upstream of the compute-unit decoder.
- Owns the PC and drives instruction-memory port 1, which has one-cycle synchronous read latency.
- Registers each fetched instruction with its PC into the ID stage and slices out opcode/funct3/funct7 for the decoder.
- Supports hazard stalls, via an internal skid buffer, and EX-stage redirects (branch/jal/jalr) that flush the instructions in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in ID when invalid

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  synchronous, active-high reset
STALL  input  1  hazard unit: hold PC, fetch and ID state
REDIRECT_VALID  input  1  EX stage: taken branch/jump this cycle
REDIRECT_PC  input  32  target address for redirect
IMEM_ADDR  output  32  instruction address (port 1), equals pc_q
IMEM_RDEN  output  1  memRead1 enable
IMEM_DOUT  input  32  instruction data, valid one cycle after address
ID_VALID  output  1  ID stage holds a real instruction
ID_PC  output  32  PC of ID instruction
ID_PC_PLUS4  output  32  ID_PC + 4 (link value for jal/jalr)
ID_INSTR  output  32  instruction in ID stage
ID_OPCODE  output  7  ID_INSTR[6:0]
ID_FUNCT3  output  3  ID_INSTR[14:12]
ID_FUNCT7  output  1  ID_INSTR[30]

Behaviour:
- State:
  - pc_q: address issued this cycle.
  - f_pc_q, f_valid_q: address issued last cycle; IMEM_DOUT belongs to it this cycle.
  - hold_instr, hold_valid: skid buffer.
  - ID registers: ID_VALID, ID_PC, ID_INSTR.
- Reset (RST=1 at edge), values after the edge:
  - pc_q=RESET_PC, f_pc_q=0, f_valid_q=0.
  - hold_valid=0, hold_instr=NOP_INSTR.
  - ID_VALID=0, ID_PC=0, ID_INSTR=NOP_INSTR.
  - RST overrides STALL and REDIRECT_VALID.
- Combinational outputs:
  - IMEM_ADDR=pc_q; IMEM_RDEN=!STALL || REDIRECT_VALID.
  - ID_OPCODE, ID_FUNCT3, ID_FUNCT7 and ID_PC_PLUS4 are derived from the ID registers only.
- Priority per edge: RST > REDIRECT_VALID > STALL > advance.
- Advance (no stall, no redirect):
  - pc_q<=pc_q+4; f_pc_q<=pc_q; f_valid_q<=1.
  - ID_PC<=f_pc_q; ID_VALID<=f_valid_q.
  - ID_INSTR<=hold_valid ? hold_instr : IMEM_DOUT when f_valid_q=1, else NOP_INSTR.
  - hold_valid<=0.
- Stall (STALL=1, no redirect):
  - pc_q, f_pc_q, f_valid_q and all ID registers hold.
  - If f_valid_q=1 and hold_valid=0: hold_instr<=IMEM_DOUT; hold_valid<=1. The instruction is captured on the first stall cycle only.
  - Later stall cycles ignore IMEM_DOUT.
- Redirect (REDIRECT_VALID=1, regardless of STALL):
  - pc_q<={REDIRECT_PC[31:2],2'b00}; f_valid_q<=0; hold_valid<=0.
  - ID_VALID<=0; ID_INSTR<=NOP_INSTR; ID_PC holds.
  - Penalty: the target reaches ID two edges after the redirect edge.
- Latency: the first reset-release edge issues RESET_PC; ID_VALID=1 with ID_PC=RESET_PC after the second advance edge.
- Arithmetic: PC is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Misaligned redirect: low two bits are forced to 0 silently.
- ID_VALID=0 always presents ID_INSTR=NOP_INSTR, so the decoder sees a harmless op.
- Reset mid-stall or mid-redirect: the reset values apply and the skid buffer content is discarded.

Test Plan:
- Reset, RESET_PC=0, memory word k=0x00100093+k, free run -> ID_VALID rises after 2nd edge with ID_PC=0, ID_INSTR=0x00100093; then ID_PC 4, 8, 12 on consecutive edges; ID_PC_PLUS4=ID_PC+4.
- Stall 3 cycles while ID_PC=8; memory changes IMEM_DOUT to 0xDEADBEEF after the 1st stall cycle -> ID holds PC 8 for 3 cycles; next ID_INSTR is the word at 12 (skid), not 0xDEADBEEF; then PC 16 follows.
- Redirect to 0x100 while ID_PC=8 -> next edge ID_VALID=0, ID_INSTR=0x00000013; the edge after, ID_VALID=0; the third edge gives ID_PC=0x100 valid; words at 12 and 16 never reach ID.
- STALL=1 and REDIRECT_VALID=1 in the same cycle, target 0x203 -> redirect wins; IMEM_ADDR=0x200 next cycle; 0x200 is valid in ID two edges later.
- PC=0xFFFFFFFC free run -> next IMEM_ADDR=0x00000000; ID_PC sequence 0xFFFFFFFC then 0.
- RST asserted during a 2-cycle stall with hold_valid=1 -> after the edge ID_VALID=0, IMEM_ADDR=RESET_PC; the held instruction never appears in ID.
